// File: rtl/loader_pkg.sv
// loader_pkg: shared types and helpers for perceptron_loader.
//
// Contents:
//   state_t    - loader FSM states (FILL, EVAL, HOLD), 2-bit encoding
//   idx_width  - element index width, max(1, $clog2(n))
//
// DATA_WIDTH defaults to 8 when the build does not define it.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package loader_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    // A 1-element vector still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/perceptron_loader.sv
// perceptron_loader: serial-to-parallel staging block in front of the perceptron.
//
// Collects N (x, w) element pairs, one per accepted beat, plus a bias sampled on
// the first beat. It then holds the assembled vectors on vec_x/vec_w/vec_b.
// One cycle later it captures the perceptron's combinational result (pe_y) into
// out_y, and offers out_y on a valid/ready output.
//
// Optional feature (macro LOADER_LAST_CHECK_EN): adds a sticky err output.
// err flags any accepted beat whose in_last disagrees with the element count.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    element beat handshake
//   in_x, in_w           signed element pair
//   in_b                 signed bias, taken on the first beat only
//   in_last              end-of-vector marker (checked only with LOADER_LAST_CHECK_EN)
//   vec_x[N], vec_w[N]   registered vectors to the perceptron
//   vec_b                registered bias to the perceptron
//   pe_y                 activated value returned by the perceptron
//   out_valid/out_ready  result handshake
//   out_y                registered result
//   busy                 high whenever the FSM is not in FILL
//   state_dbg            current FSM state, for observation
//   err                  sticky framing error (LOADER_LAST_CHECK_EN only)
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready and out_valid are pure decodes of the state
// register. Neither depends combinationally on in_valid or out_ready.

module perceptron_loader
    import loader_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_x,
    input  logic signed [DATA_WIDTH-1:0] in_w,
    input  logic signed [DATA_WIDTH-1:0] in_b,
    input  logic                         in_last,
    output logic signed [DATA_WIDTH-1:0] vec_x [N],
    output logic signed [DATA_WIDTH-1:0] vec_w [N],
    output logic signed [DATA_WIDTH-1:0] vec_b,
    input  logic signed [DATA_WIDTH-1:0] pe_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_y,
    output logic                         busy,
    output state_t                       state_dbg
`ifdef LOADER_LAST_CHECK_EN
    ,
    output logic                         err
`endif
);

    localparam int IW = idx_width(N);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic          accept;
    logic          last_beat;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);
    assign busy      = (state != FILL);
    assign state_dbg = state;

    assign accept    = in_valid && (state == FILL);
    assign last_beat = (idx == IW'(N - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && last_beat) state_nxt = EVAL;
            EVAL:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            idx   <= '0;
            vec_b <= '0;
            out_y <= '0;
            for (int i = 0; i < N; i++) begin
                vec_x[i] <= '0;
                vec_w[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                // Compare against each slot rather than indexing directly, so a
                // non-power-of-two N never addresses past the array.
                for (int i = 0; i < N; i++) begin
                    if (idx == IW'(i)) begin
                        vec_x[i] <= in_x;
                        vec_w[i] <= in_w;
                    end
                end
                if (idx == '0) begin
                    vec_b <= in_b;
                end
                idx <= last_beat ? '0 : idx + IW'(1);
            end
            // The vectors have been stable for a full cycle in EVAL, so pe_y has settled.
            if (state == EVAL) begin
                out_y <= pe_y;
            end
        end
    end

`ifdef LOADER_LAST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && (in_last != last_beat)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

endmodule

// File: tb/tb_perceptron_loader.sv
// tb_perceptron_loader: directed, self-checking bench for perceptron_loader.
// N = 4 and DATA_WIDTH = 8. The bench plays the perceptron by driving pe_y directly.
// Build with +define+LOADER_LAST_CHECK_EN to exercise the err flag as well.

module tb_perceptron_loader;
    import loader_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef logic signed [DW-1:0] vec_t [N];

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_x;
    logic signed [DW-1:0] in_w;
    logic signed [DW-1:0] in_b;
    logic                 in_last;
    logic signed [DW-1:0] vec_x [N];
    logic signed [DW-1:0] vec_w [N];
    logic signed [DW-1:0] vec_b;
    logic signed [DW-1:0] pe_y;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_y;
    logic                 busy;
    state_t               state_dbg;
`ifdef LOADER_LAST_CHECK_EN
    logic                 err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    perceptron_loader #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_b      (in_b),
        .in_last   (in_last),
        .vec_x     (vec_x),
        .vec_w     (vec_w),
        .vec_b     (vec_b),
        .pe_y      (pe_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef LOADER_LAST_CHECK_EN
        ,
        .err       (err)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic check_vectors(input string tag, input vec_t ex, input vec_t ew,
                                 input logic signed [DW-1:0] eb);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s vec_x[%0d]", tag, i), vec_x[i], ex[i]);
            check($sformatf("%s vec_w[%0d]", tag, i), vec_w[i], ew[i]);
        end
        check({tag, " vec_b"}, vec_b, eb);
    endtask

    // Drivers
    // One beat: present it after a falling edge and let the next rising edge accept it.
    // The task returns 1 ns after that rising edge.
    task automatic beat(input logic signed [DW-1:0] x, input logic signed [DW-1:0] w,
                        input logic signed [DW-1:0] b, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_b     = b;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Back-to-back vector. Beat 0 carries b0 and later beats carry b_rest.
    // in_last for beat i is lastv[i].
    task automatic load_vec(input vec_t xs, input vec_t ws, input logic signed [DW-1:0] b0,
                            input logic signed [DW-1:0] b_rest, input logic [N-1:0] lastv);
        for (int i = 0; i < N; i++) begin
            beat(xs[i], ws[i], (i == 0) ? b0 : b_rest, lastv[i]);
        end
    endtask

    // Called 1 ns after the last accepted beat (edge t), with out_ready already high.
    task automatic expect_result(input string tag, input logic signed [DW-1:0] y);
        check({tag, " EVAL state"}, 8'(state_dbg), 8'(EVAL));
        check({tag, " EVAL out_valid"}, 8'(out_valid), 8'd0);
        check({tag, " EVAL in_ready"}, 8'(in_ready), 8'd0);
        @(posedge clk);
        #1;
        check({tag, " HOLD out_valid"}, 8'(out_valid), 8'd1);
        check({tag, " out_y"}, out_y, y);
        @(posedge clk);
        #1;
        check({tag, " after xfer out_valid"}, 8'(out_valid), 8'd0);
        check({tag, " after xfer in_ready"}, 8'(in_ready), 8'd1);
        check({tag, " after xfer busy"}, 8'(busy), 8'd0);
    endtask

    vec_t x_a = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    vec_t x_b = '{8'sd4, 8'sd3, 8'sd2, 8'sd1};
    vec_t x_c = '{8'sd9, 8'sd8, 8'sd7, 8'sd6};
    vec_t w_1 = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    vec_t w_2 = '{8'sd2, 8'sd2, 8'sd2, 8'sd2};
    vec_t zv  = '{8'sd0, 8'sd0, 8'sd0, 8'sd0};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        pe_y      = 8'sd15;
        out_ready = 1'b1;

        // Reset state
        #12;
        check_vectors("reset", zv, zv, 8'sd0);
        check("reset out_y", out_y, 8'd0);
        check("reset out_valid", 8'(out_valid), 8'd0);
        check("reset busy", 8'(busy), 8'd0);
        check("reset state", 8'(state_dbg), 8'(FILL));
`ifdef LOADER_LAST_CHECK_EN
        check("reset err", 8'(err), 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", 8'(in_ready), 8'd1);

        // Basic load, back to back
        load_vec(x_a, w_1, 8'sd5, 8'sd5, 4'b1000);
        check_vectors("basic", x_a, w_1, 8'sd5);
        expect_result("basic", 8'sd15);
`ifdef LOADER_LAST_CHECK_EN
        check("clean run err", 8'(err), 8'd0);
`endif

        // Backpressure: out_y and the vectors hold, and no beat is accepted in HOLD
        out_ready = 1'b0;
        load_vec(x_b, w_1, 8'sd5, 8'sd5, 4'b1000);
        check("bp EVAL state", 8'(state_dbg), 8'(EVAL));
        @(posedge clk);
        #1;
        pe_y     = -8'sd8;
        in_valid = 1'b1;
        in_x     = 8'sd99;
        in_w     = 8'sd99;
        in_b     = 8'sd99;
        for (int c = 0; c < 6; c++) begin
            check("bp out_valid", 8'(out_valid), 8'd1);
            check("bp out_y", out_y, 8'sd15);
            check("bp in_ready", 8'(in_ready), 8'd0);
            check("bp busy", 8'(busy), 8'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_vectors("bp", x_b, w_1, 8'sd5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 8'(out_valid), 8'd0);
        check("bp release state", 8'(state_dbg), 8'(FILL));
        check("bp release out_y", out_y, 8'sd15);
        pe_y = 8'sd15;

        // Gaps between beats 1 and 2
        beat(x_a[0], w_1[0], 8'sd5, 1'b0);
        beat(x_a[1], w_1[1], 8'sd5, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("gap in_ready", 8'(in_ready), 8'd1);
            check("gap state", 8'(state_dbg), 8'(FILL));
        end
        check("gap vec_x[2] untouched", vec_x[2], 8'sd2);
        beat(x_a[2], w_1[2], 8'sd5, 1'b0);
        beat(x_a[3], w_1[3], 8'sd5, 1'b1);
        check_vectors("gap", x_a, w_1, 8'sd5);
        expect_result("gap", 8'sd15);

        // Bias sampled only on beat 0
        pe_y = 8'sd7;
        load_vec(x_b, w_2, 8'sd5, -8'sd1, 4'b1000);
        check_vectors("bias", x_b, w_2, 8'sd5);
        expect_result("bias", 8'sd7);

        // Asynchronous reset mid-load
        beat(8'sd11, 8'sd12, 8'sd13, 1'b0);
        beat(8'sd14, 8'sd15, 8'sd13, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_vectors("midreset", zv, zv, 8'sd0);
        check("midreset out_y", out_y, 8'd0);
        check("midreset out_valid", 8'(out_valid), 8'd0);
        check("midreset state", 8'(state_dbg), 8'(FILL));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset in_ready", 8'(in_ready), 8'd1);
        pe_y = -8'sd3;
        load_vec(x_c, w_2, 8'sd3, 8'sd3, 4'b1000);
        check_vectors("fresh", x_c, w_2, 8'sd3);
        expect_result("fresh", -8'sd3);

`ifdef LOADER_LAST_CHECK_EN
        // Framing error: in_last asserted on beat 1
        check("pre-frame err", 8'(err), 8'd0);
        pe_y = 8'sd21;
        beat(x_a[0], w_1[0], 8'sd4, 1'b0);
        check("frame err before bad beat", 8'(err), 8'd0);
        beat(x_a[1], w_1[1], 8'sd4, 1'b1);
        check("frame err set", 8'(err), 8'd1);
        check("frame still filling", 8'(state_dbg), 8'(FILL));
        beat(x_a[2], w_1[2], 8'sd4, 1'b0);
        beat(x_a[3], w_1[3], 8'sd4, 1'b1);
        check_vectors("frame", x_a, w_1, 8'sd4);
        expect_result("frame", 8'sd21);
        load_vec(x_b, w_2, 8'sd6, 8'sd6, 4'b1000);
        expect_result("frame clean", 8'sd21);
        check("frame err sticky", 8'(err), 8'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
